// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, issues sequential imem requests and buffers words for decode.
// Optional macro FETCH_MISALIGN_CHECK_EN adds a sticky fetch_misalign flag for misaligned redirects.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] code,
    output logic [31:0] pc,
    output logic        code_valid,
    input  logic        code_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_misalign
`endif
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] PC_MASK  = 32'hFFFF_FFFC;
    localparam logic [CW:0] DEPTH_W  = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);

    logic [31:0]   fetch_pc_r, fetch_pc_n_s;
    logic [CW-1:0] inflight_r, inflight_n_s;
    logic [CW-1:0] discard_r, discard_n_s;
    logic [CW-1:0] count_r, count_n_s;
    logic [AW-1:0] rd_ptr_r, rd_ptr_n_s;
    logic [AW-1:0] wr_ptr_r, wr_ptr_n_s;
    logic [AW-1:0] tag_rd_r, tag_rd_n_s;
    logic [AW-1:0] tag_wr_r, tag_wr_n_s;
    logic [31:0]   q_code_r [DEPTH];
    logic [31:0]   q_pc_r   [DEPTH];
    logic [31:0]   tag_r    [DEPTH];
    logic          req_ok_r, req_ok_n_s;
    logic [31:0]   code_r, code_n_s;
    logic [31:0]   pc_r, pc_n_s;
    logic          code_valid_r;
    logic          hs_s, push_s, pop_s, drop_s, blocked_s;

    // A redirect blocks the request in its own cycle; everything else comes from registered state.
    assign imem_req_valid = req_ok_r & ~redirect_valid;
    assign imem_addr      = fetch_pc_r;
    assign code           = code_r;
    assign pc             = pc_r;
    assign code_valid     = code_valid_r;

    assign hs_s   = imem_req_valid & imem_req_ready;
    assign drop_s = imem_rsp_valid & (discard_r != CNT_ZERO);
    assign push_s = imem_rsp_valid & (discard_r == CNT_ZERO) & ~redirect_valid;
    assign pop_s  = code_valid_r & code_ready & ~redirect_valid;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_r;

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= misalign_r | (redirect_valid & (redirect_pc[1:0] != 2'b00));
        end
    end

    assign blocked_s      = misalign_r | (redirect_valid & (redirect_pc[1:0] != 2'b00));
    assign fetch_misalign = misalign_r;
`else
    assign blocked_s = 1'b0;
`endif

    // Next-state for PC, counters and pointers; a redirect overrides all normal traffic.
    always_comb begin
        fetch_pc_n_s = fetch_pc_r;
        inflight_n_s = inflight_r;
        discard_n_s  = discard_r;
        count_n_s    = count_r;
        rd_ptr_n_s   = rd_ptr_r;
        wr_ptr_n_s   = wr_ptr_r;
        tag_rd_n_s   = tag_rd_r;
        tag_wr_n_s   = tag_wr_r;
        if (redirect_valid) begin
            fetch_pc_n_s = redirect_pc & PC_MASK;
            inflight_n_s = CNT_ZERO;
            // A response landing now consumes one of the outstanding slots being converted to discards.
            discard_n_s  = discard_r + inflight_r - CW'(imem_rsp_valid);
            count_n_s    = CNT_ZERO;
            rd_ptr_n_s   = PTR_ZERO;
            wr_ptr_n_s   = PTR_ZERO;
            tag_rd_n_s   = PTR_ZERO;
            tag_wr_n_s   = PTR_ZERO;
        end else begin
            fetch_pc_n_s = fetch_pc_r + (hs_s ? 32'd4 : 32'd0);
            inflight_n_s = inflight_r + CW'(hs_s) - CW'(push_s);
            discard_n_s  = discard_r - CW'(drop_s);
            count_n_s    = count_r + CW'(push_s) - CW'(pop_s);
            rd_ptr_n_s   = rd_ptr_r + AW'(pop_s);
            wr_ptr_n_s   = wr_ptr_r + AW'(push_s);
            tag_rd_n_s   = tag_rd_r + AW'(push_s);
            tag_wr_n_s   = tag_wr_r + AW'(hs_s);
        end
        req_ok_n_s = (({1'b0, inflight_n_s} + {1'b0, count_n_s}) < DEPTH_W) & ~blocked_s;
    end

    // Head-of-queue preview for the registered decode outputs, bypassing a push into an empty slot.
    always_comb begin
        code_n_s = NOP;
        pc_n_s   = pc_r;
        if (count_n_s != CNT_ZERO) begin
            if (push_s && (wr_ptr_r == rd_ptr_n_s)) begin
                code_n_s = imem_rdata;
                pc_n_s   = tag_r[tag_rd_r];
            end else begin
                code_n_s = q_code_r[rd_ptr_n_s];
                pc_n_s   = q_pc_r[rd_ptr_n_s];
            end
        end else begin
            code_n_s = NOP;
            pc_n_s   = pc_r;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r   <= RESET_PC;
            inflight_r   <= CNT_ZERO;
            discard_r    <= CNT_ZERO;
            count_r      <= CNT_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            wr_ptr_r     <= PTR_ZERO;
            tag_rd_r     <= PTR_ZERO;
            tag_wr_r     <= PTR_ZERO;
            req_ok_r     <= 1'b0;
            code_r       <= NOP;
            pc_r         <= 32'h0000_0000;
            code_valid_r <= 1'b0;
        end else begin
            fetch_pc_r   <= fetch_pc_n_s;
            inflight_r   <= inflight_n_s;
            discard_r    <= discard_n_s;
            count_r      <= count_n_s;
            rd_ptr_r     <= rd_ptr_n_s;
            wr_ptr_r     <= wr_ptr_n_s;
            tag_rd_r     <= tag_rd_n_s;
            tag_wr_r     <= tag_wr_n_s;
            req_ok_r     <= req_ok_n_s;
            code_r       <= code_n_s;
            pc_r         <= pc_n_s;
            code_valid_r <= (count_n_s != CNT_ZERO);
        end
    end

    // Instruction queue storage: word plus the PC tag of the request it answers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_code_r[i] <= NOP;
                q_pc_r[i]   <= 32'h0000_0000;
            end
        end else if (push_s) begin
            q_code_r[wr_ptr_r] <= imem_rdata;
            q_pc_r[wr_ptr_r]   <= tag_r[tag_rd_r];
        end else begin
            q_code_r[wr_ptr_r] <= q_code_r[wr_ptr_r];
            q_pc_r[wr_ptr_r]   <= q_pc_r[wr_ptr_r];
        end
    end

    // PC tags of live in-flight requests; stale requests lose their tags on redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_r[i] <= 32'h0000_0000;
            end
        end else if (hs_s) begin
            tag_r[tag_wr_r] <= fetch_pc_r;
        end else begin
            tag_r[tag_wr_r] <= tag_r[tag_wr_r];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: latency-configurable memory model plus a fetch-order scoreboard.
module tb_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0000_0000;
    logic [31:0] code;
    logic [31:0] pc;
    logic        code_valid;
    logic        code_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mem_lat = 1;
    logic [31:0] mem_q[$];
    int          due_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc = RESET_PC;

    fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rdata(imem_rdata),
        .code(code),
        .pc(pc),
        .code_valid(code_valid),
        .code_ready(code_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misalign(fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: accepted request seen mid-cycle, answered mem_lat cycles later with addr^KEY.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_q.delete();
            due_q.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back(imem_addr);
            due_q.push_back(cyc + mem_lat);
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst_n && due_q.size() > 0 && due_q[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rdata     = mem_q.pop_front() ^ KEY;
            void'(due_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rdata     = 32'hDEAD_BEEF;
        end
    end

    // Scoreboard: expected words queued at each accepted request, compared when decode pops them.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) begin
            exp_q.delete();
            exp_pc = RESET_PC;
        end else begin
            if (redirect_valid) begin
                checks++;
                if (imem_req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL req_in_redirect: imem_req_valid=%b required 0", imem_req_valid);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                checks++;
                if (imem_addr !== exp_pc) begin
                    errors++;
                    $display("FAIL req_addr: imem_addr=%h required %h", imem_addr, exp_pc);
                end
                exp_q.push_back({exp_pc ^ KEY, exp_pc});
                exp_pc = exp_pc + 32'd4;
            end
            if (!code_valid) begin
                checks++;
                if (code !== NOP) begin
                    errors++;
                    $display("FAIL empty_code: code=%h required %h", code, NOP);
                end
            end else if (code_ready && !redirect_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: code=%h pc=%h required no valid word", code, pc);
                end else begin
                    e = exp_q.pop_front();
                    if ({code, pc} !== e) begin
                        errors++;
                        $display("FAIL pop_order: code=%h pc=%h required code=%h pc=%h",
                                 code, pc, e[63:32], e[31:0]);
                    end
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        imem_req_ready = 1'b1;
        code_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0000_0000;
        mem_lat = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc = target;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({imem_req_valid, code_valid, code, pc, imem_addr} !== {1'b0, 1'b0, NOP, 32'h0, RESET_PC}) begin
            errors++;
            $display("FAIL reset_state: req_valid=%b code_valid=%b code=%h pc=%h addr=%h required 0 0 %h 0 %h",
                     imem_req_valid, code_valid, code, pc, imem_addr, NOP, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int first = -1;
        int pops = 0;
        logic [63:0] second = 64'h0;
        do_reset();
        code_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (imem_req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_req_c0: imem_req_valid=%b required 0", imem_req_valid);
                end
            end
            if (i == 1) begin
                checks++;
                if ({imem_req_valid, imem_addr} !== {1'b1, RESET_PC}) begin
                    errors++;
                    $display("FAIL stream_req_c1: valid=%b addr=%h required 1 %h", imem_req_valid, imem_addr, RESET_PC);
                end
            end
            if (code_valid && first >= 0 && second == 64'h0) second = {code, pc};
            if (code_valid && first < 0) begin
                first = i;
                checks++;
                if ({code, pc} !== {KEY, 32'h0}) begin
                    errors++;
                    $display("FAIL stream_first: code=%h pc=%h required %h 0", code, pc, KEY);
                end
            end
        end
        checks++;
        if (first != 3) begin
            errors++;
            $display("FAIL stream_latency: first code_valid at cycle %0d required 3", first);
        end
        checks++;
        if (second !== {KEY ^ 32'h4, 32'h4}) begin
            errors++;
            $display("FAIL stream_second: got %h required %h", second, {KEY ^ 32'h4, 32'h4});
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (code_valid && code_ready) pops++;
        end
        checks++;
        if (pops < 10) begin
            errors++;
            $display("FAIL stream_rate: %0d pops in 20 cycles required at least 10", pops);
        end
    endtask

    task automatic test_backpressure();
        int hs = 0;
        int pops = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) hs++;
        end
        checks++;
        if (hs != DEPTH) begin
            errors++;
            $display("FAIL bp_issue_cap: %0d requests issued required %0d", hs, DEPTH);
        end
        checks++;
        if ({imem_req_valid, code_valid, code, pc} !== {1'b0, 1'b1, KEY, 32'h0}) begin
            errors++;
            $display("FAIL bp_hold: req_valid=%b code_valid=%b code=%h pc=%h required 0 1 %h 0",
                     imem_req_valid, code_valid, code, pc, KEY);
        end
        @(posedge clk); #1;
        code_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (code_valid && code_ready) pops++;
        end
        checks++;
        if (pops < 8) begin
            errors++;
            $display("FAIL bp_release: %0d pops in 20 cycles required at least 8", pops);
        end
        @(posedge clk); #1;
        imem_req_ready = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: %0d issued words never delivered required 0", exp_q.size());
        end
    endtask

    task automatic test_req_stall();
        int hs = 0;
        int t = 0;
        do_reset();
        code_ready = 1'b1;
        while (hs < 2 && t < 20) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) hs++;
            t++;
        end
        @(posedge clk); #1;
        imem_req_ready = 1'b0;
        t = 0;
        @(negedge clk);
        while (!imem_req_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({imem_req_valid, imem_addr} !== {1'b1, 32'h8}) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d valid=%b addr=%h required 1 00000008", i, imem_req_valid, imem_addr);
            end
            if (i < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        imem_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({imem_req_valid, imem_addr} !== {1'b1, 32'h8}) begin
            errors++;
            $display("FAIL stall_accept: valid=%b addr=%h required 1 00000008", imem_req_valid, imem_addr);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_valid_pc(input string name, input logic [31:0] target);
        int t = 0;
        @(negedge clk);
        while (!code_valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if ({code_valid, code, pc} !== {1'b1, target ^ KEY, target}) begin
            errors++;
            $display("FAIL %s: valid=%b code=%h pc=%h required 1 %h %h", name, code_valid, code, pc, target ^ KEY, target);
        end
    endtask

    task automatic wait_handshakes(input int n);
        int hs = 0;
        int t = 0;
        while (hs < n && t < 30) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) hs++;
            t++;
        end
        checks++;
        if (hs != n) begin
            errors++;
            $display("FAIL hs_timeout: %0d handshakes seen required %0d", hs, n);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        mem_lat = 3;
        code_ready = 1'b1;
        wait_handshakes(2);
        pulse_redirect(32'h0000_0100);
        @(negedge clk);
        checks++;
        if (code_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush: code_valid=%b required 0", code_valid);
        end
        wait_valid_pc("redir_target", 32'h0000_0100);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_redirect_collision();
        int t = 0;
        do_reset();
        @(negedge clk);
        while (!imem_rsp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        code_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({imem_rsp_valid, code_valid} !== 2'b11) begin
            errors++;
            $display("FAIL coll_setup: rsp_valid=%b code_valid=%b required 1 1", imem_rsp_valid, code_valid);
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({code_valid, pc} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL coll_flush: code_valid=%b pc=%h required 0 00000000", code_valid, pc);
        end
        wait_valid_pc("coll_target", 32'h0000_0200);
        repeat (6) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_lat = 3;
        code_ready = 1'b1;
        wait_handshakes(2);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        @(posedge clk); #1;
        redirect_pc = 32'h0000_0400;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        wait_valid_pc("b2b_target", 32'h0000_0400);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [31:0] want [4];
        int n = 0;
        int t = 0;
        want[0] = 32'hFFFF_FFF8;
        want[1] = 32'hFFFF_FFFC;
        want[2] = 32'h0000_0000;
        want[3] = 32'h0000_0004;
        do_reset();
        code_ready = 1'b1;
        pulse_redirect(32'hFFFF_FFF8);
        while (n < 4 && t < 40) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                checks++;
                if (imem_addr !== want[n]) begin
                    errors++;
                    $display("FAIL wrap_addr%0d: imem_addr=%h required %h", n, imem_addr, want[n]);
                end
                n++;
            end
            t++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL wrap_timeout: %0d fetches seen required 4", n);
        end
        repeat (6) @(negedge clk);
    endtask

`ifdef FETCH_MISALIGN_CHECK_EN
    task automatic test_misalign();
        int issued = 0;
        do_reset();
        code_ready = 1'b1;
        pulse_redirect(32'h0000_0102);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req_valid) issued++;
        end
        checks++;
        if ({fetch_misalign, code_valid} !== 2'b10 || issued != 0) begin
            errors++;
            $display("FAIL misalign: flag=%b code_valid=%b requests=%0d required 1 0 0", fetch_misalign, code_valid, issued);
        end
    endtask
`endif

    task automatic test_mid_reset();
        do_reset();
        repeat (5) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req_valid, code_valid, code, pc, imem_addr} !== {1'b0, 1'b0, NOP, 32'h0, RESET_PC}) begin
            errors++;
            $display("FAIL mid_reset: req_valid=%b code_valid=%b code=%h pc=%h addr=%h required 0 0 %h 0 %h",
                     imem_req_valid, code_valid, code, pc, imem_addr, NOP, RESET_PC);
        end
        do_reset();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect();
        test_redirect_collision();
        test_back_to_back();
        test_wrap();
`ifdef FETCH_MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
